// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns
// (active-low, bit 6 = A ... bit 0 = G), FSM states and the decode result.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURED = 2'd2
   } seg_state_e;

   typedef struct packed {
      logic [3:0] value;
      logic       blank;
      logic       invalid;
   } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to digit decoder.
// SEG_DECODE_HEX_EN adds the A-F glyphs; without it they report invalid.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pat_i,
   output seg_dec_t   dec_o
);

   always_comb begin
      dec_o = '{value: 4'h0, blank: 1'b0, invalid: 1'b0};
      case (pat_i)
         SEG_0:     dec_o.value = 4'h0;
         SEG_1:     dec_o.value = 4'h1;
         SEG_2:     dec_o.value = 4'h2;
         SEG_3:     dec_o.value = 4'h3;
         SEG_4:     dec_o.value = 4'h4;
         SEG_5:     dec_o.value = 4'h5;
         SEG_6:     dec_o.value = 4'h6;
         SEG_7:     dec_o.value = 4'h7;
         SEG_8:     dec_o.value = 4'h8;
         SEG_9:     dec_o.value = 4'h9;
`ifdef SEG_DECODE_HEX_EN
         SEG_A:     dec_o.value = 4'hA;
         SEG_B:     dec_o.value = 4'hB;
         SEG_C:     dec_o.value = 4'hC;
         SEG_D:     dec_o.value = 4'hD;
         SEG_E:     dec_o.value = 4'hE;
         SEG_F:     dec_o.value = 4'hF;
`endif
         SEG_BLANK: dec_o.blank = 1'b1;
         default:   dec_o.invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers digit values from a multiplexed active-low seven-segment bus and
// delivers whole frames over valid/ready. Hex glyphs need SEG_DECODE_HEX_EN.
//
// state       | meaning
// ST_IDLE     | no single anode active, nothing to capture
// ST_SETTLE   | one anode active, waiting for the pattern to hold stable
// ST_CAPTURED | digit taken for this dwell, waiting for the bus to change
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an_i,
   input  logic [6:0]              seg_i,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [NUM_DIGITS-1:0]   blank_o,
   output logic [NUM_DIGITS-1:0]   invalid_o,
   output logic                    frame_valid_o,
   input  logic                    frame_ready_i,
   output logic                    overrun_o
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [NUM_DIGITS-1:0]   an_m_q, an_s_q, an_p_q;
   logic [6:0]              seg_m_q, seg_s_q, seg_p_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   seg_state_e              state_q, state_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] stage_dig_q, stage_dig_d;
   logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d;
   logic [NUM_DIGITS-1:0]   stage_inv_q, stage_inv_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
   logic                    valid_q, valid_d;
   logic                    overrun_q, overrun_d;

   logic                    sample_chg;
   logic                    an_onehot;
   logic                    cap_en;
   logic [IDX_W-1:0]        slot;
   logic                    complete;
   logic                    accept;
   seg_dec_t                dec;

   seg_pattern_decode u_decode (
      .pat_i (seg_s_q),
      .dec_o (dec)
   );

   // Synchronizers and previous-sample copy idle high like the bus itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_m_q  <= '1;
         an_s_q  <= '1;
         an_p_q  <= '1;
         seg_m_q <= '1;
         seg_s_q <= '1;
         seg_p_q <= '1;
         cnt_q   <= '0;
      end else begin
         an_m_q  <= an_i;
         an_s_q  <= an_m_q;
         an_p_q  <= an_s_q;
         seg_m_q <= seg_i;
         seg_s_q <= seg_m_q;
         seg_p_q <= seg_s_q;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      sample_chg = (an_s_q != an_p_q) || (seg_s_q != seg_p_q);
      an_onehot  = ($countones(~an_s_q) == 1);
      cnt_d      = cnt_q;
      if (sample_chg)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      slot = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (!an_s_q[k])
            slot = IDX_W'(k);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (an_onehot)
               state_d = ST_SETTLE;
         ST_SETTLE:
            if (!an_onehot)
               state_d = ST_IDLE;
            else if (cnt_d == CNT_MAX)
               state_d = ST_CAPTURED;
         ST_CAPTURED:
            if (sample_chg)
               state_d = an_onehot ? ST_SETTLE : ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // Capture lands on the edge where the count reaches its terminal value,
   // i.e. 2+STABLE_CYCLES edges after the bus value was first presented.
   always_comb begin
      cap_en = (state_q == ST_SETTLE) && an_onehot && (cnt_d == CNT_MAX);
   end

   always_comb begin
      complete      = &seen_q;
      accept        = valid_q && frame_ready_i;
      stage_dig_d   = stage_dig_q;
      stage_blank_d = stage_blank_q;
      stage_inv_d   = stage_inv_q;
      seen_d        = seen_q;
      if (cap_en) begin
         stage_dig_d[4*slot +: 4] = dec.value;
         stage_blank_d[slot]      = dec.blank;
         stage_inv_d[slot]        = dec.invalid;
         seen_d[slot]             = 1'b1;
      end
      if (complete)
         seen_d = '0;
   end

   always_comb begin
      digits_d  = digits_q;
      blank_d   = blank_q;
      invalid_d = invalid_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (complete) begin
         if (!valid_q || accept) begin
            digits_d  = stage_dig_q;
            blank_d   = stage_blank_q;
            invalid_d = stage_inv_q;
            valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q        <= '0;
         stage_dig_q   <= '0;
         stage_blank_q <= '0;
         stage_inv_q   <= '0;
         digits_q      <= '0;
         blank_q       <= '0;
         invalid_q     <= '0;
         valid_q       <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         seen_q        <= seen_d;
         stage_dig_q   <= stage_dig_d;
         stage_blank_q <= stage_blank_d;
         stage_inv_q   <= stage_inv_d;
         digits_q      <= digits_d;
         blank_q       <= blank_d;
         invalid_q     <= invalid_d;
         valid_q       <= valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign digits_o      = digits_q;
   assign blank_o       = blank_q;
   assign invalid_o     = invalid_q;
   assign frame_valid_o = valid_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed expected frames.
module tb_seg_scan_decoder;

   localparam logic [6:0] P0 = 7'b0000001;
   localparam logic [6:0] P1 = 7'b1001111;
   localparam logic [6:0] P2 = 7'b0010010;
   localparam logic [6:0] P3 = 7'b0000110;
   localparam logic [6:0] P4 = 7'b1001100;
   localparam logic [6:0] P5 = 7'b0100100;
   localparam logic [6:0] P6 = 7'b0100000;
   localparam logic [6:0] P7 = 7'b0001111;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0001100;
   localparam logic [6:0] PA = 7'b0001000;
   localparam logic [6:0] PBL = 7'b1111111;

`ifdef SEG_DECODE_HEX_EN
   localparam logic [15:0] EXP_HEX_DIG = 16'hA016;
   localparam logic [3:0]  EXP_HEX_INV = 4'b0000;
`else
   localparam logic [15:0] EXP_HEX_DIG = 16'h0016;
   localparam logic [3:0]  EXP_HEX_INV = 4'b1000;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an_i = 4'b1111;
   logic [6:0]  seg_i = 7'b1111111;
   logic        frame_ready_i = 1'b0;
   logic [15:0] digits_o;
   logic [3:0]  blank_o;
   logic [3:0]  invalid_o;
   logic        frame_valid_o;
   logic        overrun_o;

   int          n_run = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   logic [15:0] acc_dig = '0;
   logic [3:0]  acc_blank = '0;
   logic [3:0]  acc_inv = '0;

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .an_i          (an_i),
      .seg_i         (seg_i),
      .digits_o      (digits_o),
      .blank_o       (blank_o),
      .invalid_o     (invalid_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready_i),
      .overrun_o     (overrun_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && frame_valid_o && frame_ready_i) begin
         n_acc++;
         acc_dig   = digits_o;
         acc_blank = blank_o;
         acc_inv   = invalid_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an_i  = a;
      seg_i = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                             input logic [6:0] p2, input logic [6:0] p3);
      drive(4'b1110, p0, 40);
      drive(4'b1101, p1, 40);
      drive(4'b1011, p2, 40);
      drive(4'b0111, p3, 40);
      drive(4'b1111, PBL, 10);
   endtask

   initial begin
      int acc0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_digits", 32'(digits_o), 32'h0);
      chk("rst_blank", 32'(blank_o), 32'h0);
      chk("rst_invalid", 32'(invalid_o), 32'h0);
      chk("rst_valid", 32'(frame_valid_o), 32'h0);
      chk("rst_overrun", 32'(overrun_o), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame_ready_i = 1'b1;

      // basic frame 3210
      send_frame(P0, P1, P2, P3);
      chk("f1_count", 32'(n_acc), 32'd1);
      chk("f1_digits", 32'(acc_dig), 32'h3210);
      chk("f1_blank", 32'(acc_blank), 32'h0);
      chk("f1_invalid", 32'(acc_inv), 32'h0);
      chk("f1_valid_drop", 32'(frame_valid_o), 32'h0);

      // digit 0 dwell too short, then two anodes active: no frame yet
      drive(4'b1110, P5, 10);
      drive(4'b1101, P7, 40);
      drive(4'b1011, P8, 40);
      drive(4'b0111, P9, 40);
      drive(4'b1111, PBL, 10);
      chk("short_no_frame", 32'(n_acc), 32'd1);
      drive(4'b1100, P1, 40);
      drive(4'b1111, PBL, 10);
      chk("multi_an_no_frame", 32'(n_acc), 32'd1);
      drive(4'b1110, P4, 40);
      drive(4'b1111, PBL, 10);
      chk("complete_count", 32'(n_acc), 32'd2);
      chk("complete_digits", 32'(acc_dig), 32'h9874);

      // blank and hex glyph
      send_frame(P6, P1, PBL, PA);
      chk("hex_count", 32'(n_acc), 32'd3);
      chk("hex_digits", 32'(acc_dig), 32'(EXP_HEX_DIG));
      chk("hex_blank", 32'(acc_blank), 32'b0100);
      chk("hex_invalid", 32'(acc_inv), 32'(EXP_HEX_INV));

      // overrun: two frames with no ready
      frame_ready_i = 1'b0;
      send_frame(P1, P2, P3, P4);
      chk("ovr_first_valid", 32'(frame_valid_o), 32'h1);
      chk("ovr_first_flag", 32'(overrun_o), 32'h0);
      send_frame(P5, P6, P7, P8);
      chk("ovr_hold_valid", 32'(frame_valid_o), 32'h1);
      chk("ovr_hold_digits", 32'(digits_o), 32'h4321);
      chk("ovr_flag", 32'(overrun_o), 32'h1);
      acc0 = n_acc;
      frame_ready_i = 1'b1;
      @(posedge clk);
      #1;
      frame_ready_i = 1'b0;
      @(negedge clk);
      chk("ovr_accept_count", 32'(n_acc - acc0), 32'd1);
      chk("ovr_accept_digits", 32'(acc_dig), 32'h4321);
      chk("ovr_clear", 32'(overrun_o), 32'h0);
      chk("ovr_valid_drop", 32'(frame_valid_o), 32'h0);
      @(posedge clk);
      #1;
      frame_ready_i = 1'b1;

      // reset mid-frame discards partial captures
      drive(4'b1110, P5, 40);
      drive(4'b1101, P5, 40);
      rst_n = 1'b0;
      an_i  = 4'b1111;
      seg_i = PBL;
      @(negedge clk);
      chk("midrst_digits", 32'(digits_o), 32'h0);
      chk("midrst_valid", 32'(frame_valid_o), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      acc0 = n_acc;
      drive(4'b1011, P3, 40);
      drive(4'b0111, P2, 40);
      drive(4'b1111, PBL, 10);
      chk("midrst_no_frame", 32'(n_acc - acc0), 32'd0);
      drive(4'b1110, P7, 40);
      drive(4'b1101, P8, 40);
      drive(4'b1111, PBL, 10);
      chk("midrst_count", 32'(n_acc - acc0), 32'd1);
      chk("midrst_digits_post", 32'(acc_dig), 32'h2387);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Recovers binary digit values from a multiplexed, active-low seven-segment display bus (anode enables plus shared ABCDEFG segments). It is the reverse path of the team's binary-to-segment encoding. The block sits on the board-facing side of the score display, where it lets the score logic and the test fixtures read back what is actually being shown. It requires each digit pattern to hold stable, collects one pattern per digit position, and hands a complete frame to the consumer over a valid/ready handshake.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digit positions.
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before a digit is captured. Minimum 2.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `an_i`  in  NUM_DIGITS: anode enables, active-low. Bit k selects digit k.
- `seg_i`  in  7: segments, active-low (0 = lit). Bit 6 = A … bit 0 = G.
- `digits_o`  out  4*NUM_DIGITS: digit k occupies bits [4k+3:4k].
- `blank_o`  out  NUM_DIGITS: digit k was all segments off.
- `invalid_o`  out  NUM_DIGITS: digit k was an unrecognised pattern.
- `frame_valid_o`  out  1: a complete frame is held on the outputs.
- `frame_ready_i`  in  1: the consumer accepts the frame.
- `overrun_o`  out  1: sticky flag; a frame was dropped while the previous one was pending.

## Operation
- `an_i` and `seg_i` each pass through a 2-flop synchronizer. All following logic uses the synchronized values `an_s` and `seg_s`.
- Stability counter:
  - Cleared whenever `{an_s,seg_s}` differs from the previous cycle's sample.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - **IDLE**: `an_s` is not one-hot-low (no anode active, or more than one). No capture. Go to SETTLE when `an_s` becomes exactly one-hot-low.
  - **SETTLE**: when the counter equals STABLE_CYCLES-1, decode `seg_s` into slot k (the active anode), set `seen[k]`, and go to CAPTURED. Go to IDLE if `an_s` stops being one-hot-low.
  - **CAPTURED**: hold until `{an_s,seg_s}` changes. Then go to SETTLE if `an_s` is one-hot-low, otherwise IDLE. A digit is captured at most once per continuous dwell.
- Decode map (pattern, bits A..G → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9
  - 1111111 → value 0 with the blank bit set.
  - Any other pattern → value 0 with the invalid bit set.
- Recapturing a slot that is already seen overwrites its staging value. `seen` is not affected.
- Frame completion: when `seen` becomes all ones, copy the staging registers to the output registers, clear `seen`, and assert `frame_valid_o`.
- Handshake:
  - `frame_valid_o` and the output data stay stable until a cycle with `frame_valid_o && frame_ready_i`.
  - The cycle after acceptance, `frame_valid_o` deasserts unless a new frame loads in the same cycle.
- Frame completion while a frame is pending and not accepted that cycle: the new frame is discarded, `seen` is cleared, and `overrun_o` is set. `overrun_o` clears on the next accepted handshake.
- Completion in the same cycle as acceptance: the new frame loads, `frame_valid_o` stays high, and no overrun is flagged.

## Timing
- Reset values:
  - `digits_o`=0, `blank_o`=0, `invalid_o`=0, `frame_valid_o`=0, `overrun_o`=0.
  - FSM in IDLE, `seen`=0, counter=0, synchronizers all ones (bus idle).
- Capture latency: a new bus value must be held for 2+STABLE_CYCLES clocks before the staging write. The write happens on the last of those edges.
- `frame_valid_o` rises 1 cycle after the final digit's capture.
- Reset asserted mid-frame: partial captures are lost immediately and there is no output glitch beyond reset values.

## Configuration
- `SEG_DECODE_HEX_EN` defined: additional patterns decode as follows, with no invalid flag:
  - 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F
- Undefined: those six patterns flag invalid.

## Structure
- A shared package `seg_pkg` holds:
  - The segment pattern constants (0–9, A–F, blank).
  - The FSM state enum.
  - The decode-result struct {value, blank, invalid}.
- Sub-module `seg_pattern_decode`: purely combinational, 7-bit pattern to decode result. It contains the `SEG_DECODE_HEX_EN` conditional.

## Test plan
- Reset, then drive `an_i`=1110/`seg_i`=0000001, 1101/1001111, 1011/0010010, 0111/0000110, 40 cycles each, `frame_ready_i`=1 → one `frame_valid_o` pulse with `digits_o`=16'h3210, blank 0, invalid 0.
- Hold digit 0's pattern for only 10 cycles (STABLE_CYCLES=16) before switching anodes → no capture, and no frame after three digits.
- Drive `an_i`=1100 for 40 cycles → FSM stays IDLE, `seen` unchanged.
- Digit 2 = 1111111, digit 3 = 0001000 → `blank_o[2]`=1. Without `SEG_DECODE_HEX_EN`, `invalid_o[3]`=1. With it defined, digit 3=4'hA.
- Hold `frame_ready_i`=0 across two complete frames → first frame stays on outputs and `overrun_o`=1. Then assert ready for 1 cycle → `overrun_o`=0 and `frame_valid_o`=0.
- Assert `rst_n`=0 after two digits captured, then release and send a full frame → output reflects only post-reset digits.
